// File: rtl/bibus_pkg.sv
// Shared types and defaults for the bidirectional-bus arbiter.
// Holds the FSM state encoding and a one-hot to index helper.
package bibus_pkg;

    localparam int DEF_NREQ     = 3;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_TURN     = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    // Caller guarantees at most one bit set; an all-zero input maps to 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bibus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner,
// scanning upward with wrap-around.
module rr_pick
    import bibus_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_owner,
    output logic            any,
    output logic [2:0]      winner,
    output logic [NREQ-1:0] winner_oh
);

    // Walk distances from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner_oh = '0;
        for (int i = NREQ; i >= 1; i--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && ((int'(last_owner) + i == j) ||
                               (int'(last_owner) + i == j + NREQ))) begin
                    winner_oh    = '0;
                    winner_oh[j] = 1'b1;
                end
            end
        end
    end

    assign any    = |req;
    assign winner = onehot_to_idx(8'(winner_oh));

endmodule

// File: rtl/bibus_arbiter.sv
// Bus-ownership controller for the shared tri-state data bus: round-robin
// grants with a hold limit and idle turnaround cycles between owners.
//
//   state   | meaning
//   S_IDLE  | bus released, no owner, waiting for any request
//   S_GRANT | one source drives the bus, hold_cnt = cycles granted so far
//   S_TURN  | all grants low, bus Z, turn_cnt = turnaround cycles so far
module bibus_arbiter
    import bibus_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN     = DEF_TURN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            bus_busy,
    output logic [2:0]      owner,
    output logic            timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN + 1);

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [2:0]      owner_nxt;
    logic [2:0]      rr_ptr, ptr_nxt;
    logic            timeout_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [TW-1:0]   turn_cnt, turn_nxt;
    logic            pick_any;
    logic [2:0]      pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            req_owner;
    logic            issue;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last_owner (rr_ptr),
        .any        (pick_any),
        .winner     (pick_idx),
        .winner_oh  (pick_oh)
    );

    // grant is one-hot, so masking req with it yields the owner's request.
    assign req_owner = |(req & grant);
    assign bus_busy  = |grant;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        owner_nxt   = owner;
        ptr_nxt     = rr_ptr;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        turn_nxt    = turn_cnt;
        issue       = 1'b0;
        case (state)
            S_IDLE: begin
                issue = pick_any;
            end
            S_GRANT: begin
                if (!req_owner || hold_cnt == HW'(MAX_HOLD)) begin
                    state_nxt   = S_TURN;
                    grant_nxt   = '0;
                    timeout_nxt = req_owner;
                    turn_nxt    = TW'(1);
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            S_TURN: begin
                if (turn_cnt == TW'(TURN)) begin
                    issue = pick_any;
                    if (!pick_any) state_nxt = S_IDLE;
                end else begin
                    turn_nxt = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
        if (issue) begin
            state_nxt = S_GRANT;
            grant_nxt = pick_oh;
            owner_nxt = pick_idx;
            ptr_nxt   = pick_idx;
            hold_nxt  = HW'(1);
        end
    end

    // Pointer resets to the top index so req[0] wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= 3'(NREQ - 1);
            timeout  <= 1'b0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= ptr_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_nxt;
            turn_cnt <= turn_nxt;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) $onehot0(grant));

endmodule

// File: tb/tb_bibus_arbiter.sv
// Directed and randomized checks for bibus_arbiter at default parameters.
module tb_bibus_arbiter;

    localparam int NREQ     = 3;
    localparam int MAX_HOLD = 8;
    localparam int TURN     = 1;
    localparam int BOUND    = (NREQ - 1) * (MAX_HOLD + TURN) + TURN + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant;
    logic            bus_busy;
    logic [2:0]      owner;
    logic            timeout;

    int n_checks = 0;
    int n_errors = 0;

    bibus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TURN(TURN)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .bus_busy (bus_busy),
        .owner    (owner),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] grant;
        logic [2:0] owner;
        logic       to;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_g;
        logic [2:0] prev;
        int         seg;
        int         pos;
        int         zero_run;
        int         hold_run;
        bit         seen;
        int         wait_c[NREQ];

        vt[0]  = '{3'b001, 3'b001, 3'd0, 1'b0};
        vt[1]  = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[2]  = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[3]  = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[4]  = '{3'b010, 3'b010, 3'd1, 1'b0};
        vt[5]  = '{3'b010, 3'b010, 3'd1, 1'b0};
        vt[6]  = '{3'b010, 3'b010, 3'd1, 1'b0};
        vt[7]  = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[8]  = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[9]  = '{3'b101, 3'b100, 3'd2, 1'b0};
        vt[10] = '{3'b100, 3'b100, 3'd2, 1'b0};
        vt[11] = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[12] = '{3'b011, 3'b001, 3'd0, 1'b0};
        vt[13] = '{3'b010, 3'b000, 3'd0, 1'b0};
        vt[14] = '{3'b010, 3'b010, 3'd1, 1'b0};
        vt[15] = '{3'b000, 3'b000, 3'd0, 1'b0};
        vt[16] = '{3'b000, 3'b000, 3'd0, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(bus_busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b1;

        // Table: single grant/release, early release, rotation, TURN->GRANT
        for (int i = 0; i < 17; i++) begin
            req = vt[i].req;
            step();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].grant));
            chk($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(|vt[i].grant));
            chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vt[i].to));
            if (vt[i].grant != 3'b000)
                chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vt[i].owner));
        end

        // All requesting: 8-cycle grants with timeout pulse in each turnaround
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 28; k++) begin
            step();
            seg = k / (MAX_HOLD + TURN);
            pos = k % (MAX_HOLD + TURN);
            exp_g = (pos < MAX_HOLD) ? 3'(1 << (seg % NREQ)) : 3'b000;
            chk($sformatf("rot%0d_grant", k), 32'(grant), 32'(exp_g));
            chk($sformatf("rot%0d_timeout", k), 32'(timeout), (pos < MAX_HOLD) ? 0 : 1);
        end

        // Asynchronous reset while grant=100
        do_reset();
        req = 3'b100;
        step();
        chk("ar_pre_grant", 32'(grant), 32'(3'b100));
        chk("ar_pre_owner", 32'(owner), 2);
        #2 rst = 1'b0;
        #1;
        chk("ar_mid_grant", 32'(grant), 0);
        chk("ar_mid_busy", 32'(bus_busy), 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_post_grant", 32'(grant), 32'(3'b100));
        chk("ar_post_owner", 32'(owner), 2);
        @(negedge clk);

        // Request pulse inside TURN only is not latched
        do_reset();
        req = 3'b001;
        for (int k = 0; k < MAX_HOLD; k++) begin
            step();
            chk($sformatf("tp%0d_grant", k), 32'(grant), 32'(3'b001));
        end
        step();
        chk("tp_turn_grant", 32'(grant), 0);
        chk("tp_turn_timeout", 32'(timeout), 1);
        #1 req = 3'b101;
        #2 req = 3'b001;
        step();
        chk("tp_next_grant", 32'(grant), 32'(3'b001));
        chk("tp_next_owner", 32'(owner), 0);
        chk("tp_next_timeout", 32'(timeout), 0);

        // Random traffic with protocol checkers
        do_reset();
        prev     = '0;
        zero_run = 0;
        hold_run = 0;
        seen     = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            step();
            chk("rnd_onehot", 32'($onehot0(grant)), 1);
            if (grant != 3'b000) begin
                if (grant == prev) begin
                    hold_run++;
                end else begin
                    if (seen) chk("rnd_gap", 32'(prev == 3'b000 && zero_run >= TURN), 1);
                    hold_run = 1;
                    seen     = 1'b1;
                end
                chk("rnd_hold", 32'(hold_run <= MAX_HOLD), 1);
            end else begin
                zero_run = (prev == 3'b000) ? zero_run + 1 : 1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !prev[i]) begin
                    chk($sformatf("rnd_latency%0d", i), 32'(wait_c[i] <= BOUND), 1);
                    wait_c[i] = 0;
                end else if (req[i] && !grant[i]) begin
                    wait_c[i]++;
                end else begin
                    wait_c[i] = 0;
                end
            end
            prev = grant;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) req[i] = ($urandom_range(3) == 0);
                else if (grant[i] && $urandom_range(5) == 0) req[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("rnd_final_wait%0d", i), 32'(wait_c[i] <= BOUND), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
